// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter in front of a register file: round-robin grant between the
// ALU and load writeback paths, one registered write per cycle, writes to r0 counted and dropped.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  req0_valid,
    input  logic [REG_WIDTH-1:0]  req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REG_WIDTH-1:0]  req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_write_en,
    output logic [REG_WIDTH-1:0]  rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  grant_id,
    output logic [7:0]            drop_cnt
);

    logic                  ptr;        // 0: requester 0 wins a tie, 1: requester 1 wins
    logic                  grant0;
    logic                  grant1;
    logic                  xfer;
    logic [REG_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !hold) begin
            if (req0_valid && (!req1_valid || !ptr))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;
    assign sel_addr   = grant1 ? req1_addr : req0_addr;
    assign sel_data   = grant1 ? req1_data : req0_data;

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= 1'b0;
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            grant_id      <= 1'b0;
            drop_cnt      <= 8'd0;
        end else begin
            rf_write_en <= xfer && (sel_addr != '0);
            if (xfer) begin
                rf_write_addr <= sel_addr;
                rf_write_data <= sel_data;
                grant_id      <= grant1;
                ptr           <= grant0;   // point at whoever lost this round
                if (sel_addr == '0 && drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the register data width.
REQ-002 The module SHALL have parameter REG_WIDTH, default 8, meaning the register address width.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 hold  input  1  pipeline hold; when high, no grant is issued.
REQ-006 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-007 req0_addr  input  REG_WIDTH  requester 0 destination register.
REQ-008 req0_data  input  DATA_WIDTH  requester 0 write data.
REQ-009 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-010 req1_valid  input  1  requester 1 (load writeback) has a write pending.
REQ-011 req1_addr  input  REG_WIDTH  requester 1 destination register.
REQ-012 req1_data  input  DATA_WIDTH  requester 1 write data.
REQ-013 req1_ready  output  1  requester 1 write accepted this cycle.
REQ-014 rf_write_en  output  1  register file write enable, registered.
REQ-015 rf_write_addr  output  REG_WIDTH  register file write address, registered.
REQ-016 rf_write_data  output  DATA_WIDTH  register file write data, registered.
REQ-017 grant_id  output  1  requester whose write is on rf_* this cycle, registered.
REQ-018 drop_cnt  output  8  saturating count of accepted writes to register 0.

Function
REQ-019 A transfer on port i SHALL occur in a cycle where reqi_valid and reqi_ready are both high at the rising edge.
REQ-020 reqi_ready SHALL be combinational from current valids, hold and priority pointer; at most one ready high per cycle.
REQ-021 With hold high, both ready outputs SHALL be 0 and the pointer SHALL not change.
REQ-022 With hold low and exactly one valid, that requester SHALL be granted regardless of pointer.
REQ-023 With hold low and both valid, the requester selected by the 1-bit priority pointer SHALL be granted.
REQ-024 After any transfer, the pointer SHALL be set to the non-granted requester (round-robin).
REQ-025 No cycle with hold low and any valid high SHALL pass without exactly one grant.
REQ-026 A requester continuously valid with hold low SHALL be granted within 2 cycles.
REQ-027 A transfer SHALL drive rf_write_addr/rf_write_data/grant_id with the accepted values on the next cycle (latency 1).
REQ-028 rf_write_en SHALL be 1 in the cycle after a transfer with addr != 0, else 0.
REQ-029 A transfer with addr == 0 SHALL be acknowledged (ready high), update the pointer, produce rf_write_en = 0, and increment drop_cnt.
REQ-030 drop_cnt SHALL saturate at 255 and never wrap.
REQ-031 rf_write_addr/rf_write_data/grant_id SHALL hold their last value in cycles without a transfer.
REQ-032 Simultaneous valids to the same address SHALL be serialized in grant order; no merging; the later grant's data is written last.
REQ-033 Requesters SHALL keep valid/addr/data stable until ready; the arbiter SHALL sample them only in the transfer cycle.

Reset
REQ-034 While rst is high: both ready = 0, rf_write_en = 0, rf_write_addr = 0, rf_write_data = 0, grant_id = 0, drop_cnt = 0, pointer = 0 (requester 0 first).
REQ-035 rst asserted mid-operation SHALL clear all state immediately; a write pending on rf_* SHALL be discarded (rf_write_en = 0 asynchronously).
REQ-036 First grant after rst deassertion SHALL follow REQ-022/023 with pointer = 0.

Verification
REQ-037 Reset then req0_valid=1 addr=5 data=0xA5, req1 idle -> req0_ready=1 same cycle; next cycle rf_write_en=1 addr=5 data=0xA5 grant_id=0.
REQ-038 Both valid for 4 cycles (req0 addr=1, req1 addr=2), pointer=0 -> grants 0,1,0,1; rf_write_addr sequence 1,2,1,2 one cycle later.
REQ-039 req1_valid=1 addr=0 data=0xFF -> req1_ready=1; next cycle rf_write_en=0; drop_cnt 0->1; 256 such writes -> drop_cnt=255.
REQ-040 hold=1 with both valid for 3 cycles -> both ready=0, rf_write_en=0; hold=0 -> req0 granted first (pointer unchanged).
REQ-041 Both valid to addr=7 (req0 data=0x11, req1 data=0x22) -> writes 0x11 then 0x22 on consecutive cycles.
REQ-042 rst pulsed in cycle after a transfer to addr=3 -> rf_write_en drops to 0 during rst; all outputs 0; pointer=0 after release.
